// File: rtl/dbl_op_exec.sv
`default_nettype none
// ============================================================================
// Module   : dbl_op_exec
// Brief    : Multi-cycle executor for format-I double-operand instructions
//            over a small register file. An instruction walks through
//            IDLE -> DECODE -> READ -> EXEC -> WB. Illegal encodings are
//            rejected from DECODE.
// Ports    : clk, rst             clock and synchronous active-high reset
//            start, instr         launch request and 16-bit instruction word
//            load_en/addr/data    register preload (accepted only in IDLE)
//            dbg_addr, dbg_data   combinational register read-back
//            busy, done, illegal  status; done is a one-cycle pulse
//            res, flags, fsm      last result, {V,N,Z,C}, current state
// Revision : 1.0 - initial release
// ============================================================================
module dbl_op_exec #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       instr,
    input  logic              load_en,
    input  logic [REG_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        flags,
    output logic [2:0]        fsm
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_read   = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;

    localparam logic [3:0] c_op_mov  = 4'h4;
    localparam logic [3:0] c_op_add  = 4'h5;
    localparam logic [3:0] c_op_addc = 4'h6;
    localparam logic [3:0] c_op_subc = 4'h7;
    localparam logic [3:0] c_op_sub  = 4'h8;
    localparam logic [3:0] c_op_cmp  = 4'h9;
    localparam logic [3:0] c_op_dadd = 4'hA;
    localparam logic [3:0] c_op_bit  = 4'hB;
    localparam logic [3:0] c_op_bic  = 4'hC;
    localparam logic [3:0] c_op_bis  = 4'hD;
    localparam logic [3:0] c_op_xor  = 4'hE;
    localparam logic [3:0] c_op_and  = 4'hF;

    localparam logic [DATA_W-1:0] c_mask_byte = {{(DATA_W-8){1'b0}}, 8'hFF};
    localparam logic [31:0]       c_nregs     = 32'(NREGS);

    logic [2:0]        r_state;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_res;
    logic [3:0]        r_flags;
    logic              r_done;
    logic              r_illegal;
    logic [DATA_W-1:0] r_regs [0:NREGS-1];

    // Instruction fields, taken from the word captured when start was accepted
    logic [3:0]        w_op;
    logic [3:0]        w_src_f;
    logic [3:0]        w_dst_f;
    logic              w_ad;
    logic              w_bw;
    logic [1:0]        w_as;
    logic [REG_AW-1:0] w_src;
    logic [REG_AW-1:0] w_dst;
    logic              w_legal;
    logic              w_wb_en;
    logic              w_load_ok;
    logic              w_dbg_ok;

    assign w_op    = r_instr[15:12];
    assign w_src_f = r_instr[11:8];
    assign w_ad    = r_instr[7];
    assign w_bw    = r_instr[6];
    assign w_as    = r_instr[5:4];
    assign w_dst_f = r_instr[3:0];
    assign w_src   = REG_AW'(w_src_f);
    assign w_dst   = REG_AW'(w_dst_f);

    // Register-index range is judged on the full 4-bit field so that a
    // narrow REG_AW cannot alias an out-of-range index onto a real register.
    assign w_legal = (w_op >= c_op_mov) && (w_op != c_op_dadd) &&
                     (w_as == 2'b00) && !w_ad &&
                     ({28'd0, w_src_f} < c_nregs) &&
                     ({28'd0, w_dst_f} < c_nregs);

    // CMP and BIT only produce flags; the destination register is kept.
    assign w_wb_en   = (w_op != c_op_cmp) && (w_op != c_op_bit);
    assign w_load_ok = ({{(32-REG_AW){1'b0}}, load_addr} < c_nregs);
    assign w_dbg_ok  = ({{(32-REG_AW){1'b0}}, dbg_addr} < c_nregs);

    // ------------------------------------------------------------------
    // Execute datapath. All arithmetic is a single adder D + B + cin where
    // subtraction supplies B = ~S; operands are masked to the effective
    // width so byte results come out zero-extended and the carry lands in
    // bit 8.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_sm;
    logic [DATA_W-1:0] w_b;
    logic              w_cin;
    logic              w_arith;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_msb_a;
    logic              w_msb_b;
    logic              w_msb_s;
    logic              w_msb_r;
    logic              w_z;
    logic [3:0]        w_flags_nxt;

    always_comb begin
        w_mask  = w_bw ? c_mask_byte : {DATA_W{1'b1}};
        w_a     = r_d & w_mask;
        w_sm    = r_s & w_mask;
        w_b     = w_sm;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (w_op)
            c_op_add:  w_arith = 1'b1;
            c_op_addc: begin
                w_arith = 1'b1;
                w_cin   = r_flags[0];
            end
            c_op_subc: begin
                w_arith = 1'b1;
                w_b     = ~r_s & w_mask;
                w_cin   = r_flags[0];
            end
            c_op_sub, c_op_cmp: begin
                w_arith = 1'b1;
                w_b     = ~r_s & w_mask;
                w_cin   = 1'b1;
            end
            default: ;
        endcase

        w_sum = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};

        case (w_op)
            c_op_mov:           w_result = w_sm;
            c_op_bit, c_op_and: w_result = w_a & w_sm;
            c_op_bic:           w_result = w_a & ~w_sm;
            c_op_bis:           w_result = w_a | w_sm;
            c_op_xor:           w_result = w_a ^ w_sm;
            default:            w_result = w_sum[DATA_W-1:0] & w_mask;
        endcase

        w_carry = w_bw ? w_sum[8]    : w_sum[DATA_W];
        w_msb_a = w_bw ? w_a[7]      : w_a[DATA_W-1];
        w_msb_b = w_bw ? w_b[7]      : w_b[DATA_W-1];
        w_msb_s = w_bw ? w_sm[7]     : w_sm[DATA_W-1];
        w_msb_r = w_bw ? w_result[7] : w_result[DATA_W-1];
        w_z     = (w_result == '0);

        // Default keeps flags: MOV, BIC and BIS leave them untouched.
        w_flags_nxt = r_flags;
        if (w_arith) begin
            // Overflow: both addends share a sign that the sum does not.
            w_flags_nxt = {(w_msb_a == w_msb_b) && (w_msb_r != w_msb_a),
                           w_msb_r, w_z, w_carry};
        end else if ((w_op == c_op_and) || (w_op == c_op_bit)) begin
            w_flags_nxt = {1'b0, w_msb_r, w_z, ~w_z};
        end else if (w_op == c_op_xor) begin
            w_flags_nxt = {w_msb_s & w_msb_a, w_msb_r, w_z, ~w_z};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_instr   <= '0;
            r_s       <= '0;
            r_d       <= '0;
            r_res     <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_instr <= instr;
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    if (w_legal) begin
                        r_state <= c_st_read;
                    end else begin
                        r_state   <= c_st_idle;
                        r_done    <= 1'b1;
                        r_illegal <= 1'b1;
                    end
                end
                c_st_read: begin
                    r_s     <= r_regs[w_src];
                    r_d     <= r_regs[w_dst];
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    r_res   <= w_result;
                    r_flags <= w_flags_nxt;
                    r_state <= c_st_wb;
                end
                c_st_wb: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b1;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Register file: preload is only honoured in IDLE, writeback only in WB,
    // so the two write sources can never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == c_st_idle) && load_en && w_load_ok) begin
            r_regs[load_addr] <= load_data;
        end else if ((r_state == c_st_wb) && w_wb_en) begin
            r_regs[w_dst] <= r_res;
        end
    end

    assign dbg_data = w_dbg_ok ? r_regs[dbg_addr] : '0;
    assign busy     = (r_state != c_st_idle);
    assign done     = r_done;
    assign illegal  = r_illegal;
    assign res      = r_res;
    assign flags    = r_flags;
    assign fsm      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dbl_op_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbl_op_exec
// Brief    : Self-checking bench for dbl_op_exec. Directed scenarios plus
//            randomized instructions compared against an arithmetic
//            reference model of the register file, result and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbl_op_exec;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   instr;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          busy;
    logic          done;
    logic          illegal;
    logic [DW-1:0] res;
    logic [3:0]    flags;
    logic [2:0]    fsm;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned m_regs [NR];
    logic [3:0]  m_flags;
    int unsigned m_res;

    dbl_op_exec #(.DATA_W(DW), .NREGS(NR), .REG_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .instr     (instr),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .res       (res),
        .flags     (flags),
        .fsm       (fsm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input int idx);
        dbg_addr = AW'(idx);
        #1;
        check(tag, 32'(dbg_data), m_regs[idx]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
        m_flags = 4'h0;
        m_res   = 0;
    endtask

    function automatic longint sx(input longint unsigned x, input int w);
        if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    // Reference: plain integer arithmetic at width W, overflow judged by
    // whether the exact signed result fits in W bits.
    task automatic model_exec(input logic [15:0] ins, output bit ill);
        int op, src, dst, w;
        longint unsigned mask, s, d, full, r;
        longint sr, lim;
        bit c, v, cc, z, n, arith, upd;
        op  = int'(ins[15:12]);
        src = int'(ins[11:8]);
        dst = int'(ins[3:0]);
        ill = (op < 4) || (op == 10) || (ins[5:4] != 2'b00) || (ins[7] == 1'b1) ||
              (src >= NR) || (dst >= NR);
        if (ill) return;
        w     = ins[6] ? 8 : DW;
        mask  = (64'd1 << w) - 64'd1;
        s     = m_regs[src] & mask;
        d     = m_regs[dst] & mask;
        c     = m_flags[0];
        v     = m_flags[3];
        cc    = c;
        arith = 1'b0;
        upd   = 1'b1;
        r     = 0;
        full  = 0;
        sr    = 0;
        case (op)
            4:       begin r = s; upd = 1'b0; end
            5:       begin arith = 1'b1; full = d + s; sr = sx(d, w) + sx(s, w); end
            6:       begin arith = 1'b1; full = d + s + c; sr = sx(d, w) + sx(s, w) + longint'(c); end
            7:       begin arith = 1'b1; full = d + ((~s) & mask) + c; sr = sx(d, w) - sx(s, w) - 1 + longint'(c); end
            8, 9:    begin arith = 1'b1; full = d + ((~s) & mask) + 1; sr = sx(d, w) - sx(s, w); end
            11, 15:  begin r = d & s; v = 1'b0; end
            12:      begin r = d & (~s) & mask; upd = 1'b0; end
            13:      begin r = d | s; upd = 1'b0; end
            14:      begin r = d ^ s; v = (((s >> (w - 1)) & (d >> (w - 1)) & 64'd1) != 0); end
            default: ;
        endcase
        if (arith) begin
            r   = full & mask;
            cc  = ((full >> w) & 64'd1) != 0;
            lim = longint'(1) << (w - 1);
            v   = (sr < -lim) || (sr > lim - 1);
        end
        n = ((r >> (w - 1)) & 64'd1) != 0;
        z = (r == 0);
        if (op == 11 || op == 14 || op == 15) cc = !z;
        m_res = 32'(r);
        if (upd) m_flags = {v, n, z, cc};
        if (op != 9 && op != 11) m_regs[dst] = 32'(r);
    endtask

    task automatic load_reg(input int a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        tick();
        load_en = 1'b0;
        if (a < NR) m_regs[a] = 32'(d);
    endtask

    // Issues one instruction (optionally with a preload in the same cycle),
    // optionally pulsing start/load_en while busy, then checks latency,
    // status, result, flags and the touched registers.
    task automatic run_instr(input string tag, input logic [15:0] ins, input bit noise,
                             input bit do_load, input int laddr, input logic [DW-1:0] ldata);
        bit exp_ill, got_done;
        int lat;
        if (do_load && laddr < NR) m_regs[laddr] = 32'(ldata);
        model_exec(ins, exp_ill);
        instr     = ins;
        start     = 1'b1;
        load_en   = do_load;
        load_addr = AW'(laddr);
        load_data = ldata;
        tick();
        start    = 1'b0;
        load_en  = 1'b0;
        got_done = 1'b0;
        lat      = 0;
        for (int k = 1; k <= 8 && !got_done; k++) begin
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                load_en   = 1'($urandom_range(0, 1));
                load_addr = AW'($urandom);
                load_data = DW'($urandom);
            end
            tick();
            if (done) begin
                got_done = 1'b1;
                lat      = k;
            end
        end
        start   = 1'b0;
        load_en = 1'b0;
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_lat"}, 32'(lat), exp_ill ? 32'd1 : 32'd4);
        check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_res"}, 32'(res), m_res);
        check({tag, "_flags"}, 32'(flags), 32'(m_flags));
        check_reg({tag, "_dst"}, int'(ins[3:0]));
        check_reg({tag, "_src"}, int'(ins[11:8]));
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_noqueue"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_done;
        logic [15:0] ins;
        rst       = 1'b1;
        start     = 1'b0;
        instr     = 16'h0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        dbg_addr  = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        check("rst_fsm", 32'(fsm), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check_reg("rst_r3", 3);

        // Signed overflow on a word add
        load_reg(4, 16'h7FFF);
        load_reg(5, 16'h0001);
        run_instr("add_w", 16'h5405, 1'b0, 1'b0, 0, '0);
        dbg_addr = AW'(5); #1;
        check("add_w_r5", 32'(dbg_data), 32'h8000);
        check("add_w_vnzc", 32'(flags), 32'b1000 | 32'b0100);

        // Byte add: upper bytes discarded, carry from bit 7
        load_reg(6, 16'h12FF);
        load_reg(7, 16'h3401);
        run_instr("add_b", 16'h5647, 1'b0, 1'b0, 0, '0);
        dbg_addr = AW'(7); #1;
        check("add_b_r7", 32'(dbg_data), 32'h0000);
        check("add_b_vnzc", 32'(flags), 32'b0011);

        // CMP keeps destination, SUBC then consumes C=1
        load_reg(8, 16'd5);
        load_reg(9, 16'd5);
        run_instr("cmp", 16'h9809, 1'b0, 1'b0, 0, '0);
        dbg_addr = AW'(9); #1;
        check("cmp_r9", 32'(dbg_data), 32'd5);
        check("cmp_vnzc", 32'(flags), 32'b0011);
        run_instr("subc", 16'h7809, 1'b0, 1'b0, 0, '0);
        dbg_addr = AW'(9); #1;
        check("subc_r9", 32'(dbg_data), 32'd0);
        check("subc_c", 32'(flags[0]), 32'd1);

        // Illegal addressing mode, with start/load noise while busy
        run_instr("ill_as", 16'h5415, 1'b1, 1'b0, 0, '0);

        // Preload and start in the same cycle; READ must see the new value
        load_reg(11, 16'h0100);
        run_instr("ld_start", 16'h5A0B, 1'b0, 1'b1, 10, 16'h1234);
        dbg_addr = AW'(11); #1;
        check("ld_start_r11", 32'(dbg_data), 32'h1334);

        // Reset while in EXEC cancels the instruction and clears everything
        load_reg(4, 16'h1111);
        load_reg(5, 16'h2222);
        instr = 16'h5405;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rst_mid_pre", 32'(fsm), 32'd3);
        rst = 1'b1;
        tick();
        check("rst_mid_fsm", 32'(fsm), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst      = 1'b0;
        any_done = done;
        for (int k = 0; k < 6; k++) begin
            tick();
            any_done |= done;
        end
        check("rst_mid_nodone", 32'(any_done), 32'd0);
        check("rst_mid_res", 32'(res), 32'd0);
        check("rst_mid_flags", 32'(flags), 32'd0);
        model_reset();
        for (int i = 0; i < NR; i++) check_reg("rst_mid_reg", i);

        // Randomized instructions against the reference model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) load_reg(int'($urandom_range(0, NR - 1)), DW'($urandom));
            if ($urandom_range(0, 1) == 1) load_reg(int'($urandom_range(0, NR - 1)), DW'($urandom));
            ins[15:12] = 4'($urandom_range(0, 15));
            ins[11:8]  = 4'($urandom_range(0, 15));
            ins[7]     = ($urandom_range(0, 7) == 0);
            ins[6]     = 1'($urandom_range(0, 1));
            ins[5:4]   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ins[3:0]   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                run_instr("rnd_ld", ins, 1'b1, 1'b1, int'($urandom_range(0, NR - 1)), DW'($urandom));
            else
                run_instr("rnd", ins, 1'($urandom_range(0, 1)), 1'b0, 0, '0);
        end
        for (int i = 0; i < NR; i++) check_reg("final_reg", i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
